// File: rtl/cache_lru_ctrl.sv
// LRU age read-modify-write sequencer for a 4-way, way-partitioned (DAWG) cache.
// One access at a time: read the set's ages, pick a victim within the domain mask, write back.
module cache_lru_ctrl #(
    parameter int WAY_NUM      = 4,
    parameter int WAY_NUM_BITS = 2,
    parameter int CACHE_LINES  = 1024,
    parameter int INDEX_BITS   = $clog2(CACHE_LINES)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [INDEX_BITS-1:0]           req_index,
    input  logic                            req_hit,
    input  logic [WAY_NUM_BITS-1:0]         req_way,
    input  logic [WAY_NUM-1:0]              req_way_mask,
    output logic                            resp_valid,
    input  logic                            resp_ready,
    output logic [WAY_NUM_BITS-1:0]         resp_way,
    output logic                            resp_err,
    output logic [INDEX_BITS-1:0]           lru_index,
    output logic                            lru_req_we,
    output logic [WAY_NUM*WAY_NUM_BITS-1:0] lru_write,
    input  logic [WAY_NUM*WAY_NUM_BITS-1:0] lru_read,
    output logic [1:0]                      dbg_state
);

    // Handshakes: a transfer happens on a rising clk edge where valid && ready are both high;
    // valid holds its payload stable until that edge, and ready never depends on valid.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                            state_q, state_d;
    logic                              req_ready_q, req_ready_d;
    logic                              resp_valid_q, resp_valid_d;
    logic [WAY_NUM_BITS-1:0]           resp_way_q, resp_way_d;
    logic                              resp_err_q, resp_err_d;
    logic [INDEX_BITS-1:0]             lru_index_q, lru_index_d;
    logic                              lru_req_we_q, lru_req_we_d;
    logic [WAY_NUM*WAY_NUM_BITS-1:0]   lru_write_q, lru_write_d;
    logic                              hit_q, hit_d;
    logic [WAY_NUM_BITS-1:0]           way_q, way_d;
    logic [WAY_NUM-1:0]                mask_q, mask_d;

    logic [WAY_NUM_BITS-1:0]           age_rd  [WAY_NUM];
    logic [WAY_NUM_BITS-1:0]           new_age [WAY_NUM];
    logic [WAY_NUM*WAY_NUM_BITS-1:0]   new_write;
    logic [WAY_NUM_BITS-1:0]           victim;
    logic [WAY_NUM_BITS-1:0]           best_age;
    logic [WAY_NUM_BITS-1:0]           target;
    logic [WAY_NUM_BITS-1:0]           ref_age;
    logic                              found;
    logic                              acc_err;

    // Age update, evaluated against the captured request and the current memory read.
    always_comb begin
        for (int i = 0; i < WAY_NUM; i++) begin
            age_rd[i] = lru_read[i*WAY_NUM_BITS +: WAY_NUM_BITS];
        end

        // Oldest masked way wins; strict compare keeps ties on the lowest index.
        found    = 1'b0;
        best_age = '0;
        victim   = '0;
        for (int i = 0; i < WAY_NUM; i++) begin
            if (mask_q[i] && (!found || (age_rd[i] > best_age))) begin
                found    = 1'b1;
                best_age = age_rd[i];
                victim   = WAY_NUM_BITS'(i);
            end
        end

        acc_err = (mask_q == '0) || (hit_q && !mask_q[way_q]);
        target  = hit_q ? way_q : victim;
        ref_age = hit_q ? age_rd[way_q] : WAY_NUM_BITS'(WAY_NUM - 1);

        // Only masked ways move, so other domains keep their replacement order.
        new_write = '0;
        for (int i = 0; i < WAY_NUM; i++) begin
            new_age[i] = age_rd[i];
            if (mask_q[i]) begin
                if (WAY_NUM_BITS'(i) == target) begin
                    new_age[i] = '0;
                end else if (age_rd[i] < ref_age) begin
                    new_age[i] = age_rd[i] + WAY_NUM_BITS'(1);
                end
            end
            new_write[i*WAY_NUM_BITS +: WAY_NUM_BITS] = new_age[i];
        end
    end

    always_comb begin
        state_d      = state_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_way_d   = resp_way_q;
        resp_err_d   = resp_err_q;
        lru_index_d  = lru_index_q;
        lru_req_we_d = 1'b0;
        lru_write_d  = lru_write_q;
        hit_d        = hit_q;
        way_d        = way_q;
        mask_d       = mask_q;

        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid) begin
                    hit_d       = req_hit;
                    way_d       = req_way;
                    mask_d      = req_way_mask;
                    lru_index_d = req_index;
                    req_ready_d = 1'b0;
                    state_d     = READ;
                end
            end
            READ: begin
                if (acc_err) begin
                    resp_err_d   = 1'b1;
                    resp_way_d   = '0;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end else begin
                    lru_write_d  = new_write;
                    lru_req_we_d = 1'b1;
                    resp_way_d   = target;
                    resp_err_d   = 1'b0;
                    state_d      = WRITE;
                end
            end
            WRITE: begin
                resp_valid_d = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                    req_ready_d  = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_way_q   <= '0;
            resp_err_q   <= 1'b0;
            lru_index_q  <= '0;
            lru_req_we_q <= 1'b0;
            lru_write_q  <= '0;
            hit_q        <= 1'b0;
            way_q        <= '0;
            mask_q       <= '0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_way_q   <= resp_way_d;
            resp_err_q   <= resp_err_d;
            lru_index_q  <= lru_index_d;
            lru_req_we_q <= lru_req_we_d;
            lru_write_q  <= lru_write_d;
            hit_q        <= hit_d;
            way_q        <= way_d;
            mask_q       <= mask_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_way   = resp_way_q;
    assign resp_err   = resp_err_q;
    assign lru_index  = lru_index_q;
    assign lru_req_we = lru_req_we_q;
    assign lru_write  = lru_write_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_cache_lru_ctrl.sv
// Bench for cache_lru_ctrl: directed plan steps, reset abort, then random accesses
// checked against a per-set age model and an LRU memory model.
module tb_cache_lru_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [9:0]  req_index;
    logic        req_hit;
    logic [1:0]  req_way;
    logic [3:0]  req_way_mask;
    logic        resp_valid;
    logic        resp_ready;
    logic [1:0]  resp_way;
    logic        resp_err;
    logic [9:0]  lru_index;
    logic        lru_req_we;
    logic [7:0]  lru_write;
    logic [7:0]  lru_read;
    logic [1:0]  dbg_state;

    logic [7:0]  mem [0:1023];
    logic        mem_clr;
    logic        pl_en;
    logic [9:0]  pl_idx;
    logic [7:0]  pl_data;

    int          ref_age [0:1023][0:3];
    logic [2:0]  exp_q[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    cache_lru_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_index    (req_index),
        .req_hit      (req_hit),
        .req_way      (req_way),
        .req_way_mask (req_way_mask),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_way     (resp_way),
        .resp_err     (resp_err),
        .lru_index    (lru_index),
        .lru_req_we   (lru_req_we),
        .lru_write    (lru_write),
        .lru_read     (lru_read),
        .dbg_state    (dbg_state)
    );

    // LRU memory: combinational read, write on the clock edge.
    assign lru_read = mem[lru_index];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
        end else if (lru_req_we) begin
            mem[lru_index] <= lru_write;
        end else if (pl_en) begin
            mem[pl_idx] <= pl_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pack(input int a [4]);
        logic [7:0] p;
        p = '0;
        for (int i = 0; i < 4; i++) p[2*i +: 2] = a[i][1:0];
        return p;
    endfunction

    function automatic logic [7:0] pack_ref(input logic [9:0] idx);
        int a [4];
        for (int i = 0; i < 4; i++) a[i] = ref_age[idx][i];
        return pack(a);
    endfunction

    // Reference: victim = oldest masked way (lowest index on ties); target -> 0;
    // masked ways younger than the reference age get one older.
    task automatic model(input logic [9:0] idx, input logic hit, input logic [1:0] way,
                         input logic [3:0] mask, output logic err, output int tgt,
                         output int na [4]);
        int a [4];
        int best;
        int ra;
        for (int i = 0; i < 4; i++) a[i] = ref_age[idx][i];
        err = (mask == 4'b0000) || (hit && !mask[way]);
        best = -1;
        tgt = 0;
        if (hit) tgt = int'(way);
        else begin
            for (int i = 0; i < 4; i++)
                if (mask[i] && a[i] > best) begin best = a[i]; tgt = i; end
        end
        ra = hit ? a[way] : 3;
        for (int i = 0; i < 4; i++) begin
            if (!mask[i]) na[i] = a[i];
            else if (i == tgt) na[i] = 0;
            else if (a[i] < ra) na[i] = a[i] + 1;
            else na[i] = a[i];
        end
    endtask

    task automatic preload(input logic [9:0] idx, input int a [4]);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = idx; pl_data = pack(a);
        for (int i = 0; i < 4; i++) ref_age[idx][i] = a[i];
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic access(input logic [9:0] idx, input logic hit, input logic [1:0] way,
                          input logic [3:0] mask, input int hold);
        logic       err;
        int         tgt;
        int         na [4];
        int         cyc, we_cnt, we_cyc, rv_cyc;
        logic [2:0] e;
        logic [1:0] way_s;
        logic       err_s;
        model(idx, hit, way, mask, err, tgt, na);
        exp_q.push_back({err, tgt[1:0]});
        @(negedge clk);
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_index = idx; req_hit = hit; req_way = way; req_way_mask = mask;
        resp_ready = (hold == 0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_index = 10'($urandom); req_hit = 1'($urandom);
        req_way = 2'($urandom); req_way_mask = 4'($urandom);
        cyc = 0; we_cnt = 0; we_cyc = -1; rv_cyc = -1;
        while (rv_cyc < 0 && cyc < 12) begin
            @(negedge clk);
            cyc++;
            if (lru_req_we) begin
                we_cnt++; we_cyc = cyc;
                chk("we_index", lru_index, idx);
                chk("we_data", lru_write, pack(na));
            end
            if (resp_valid) rv_cyc = cyc;
        end
        chk("resp_timeout", rv_cyc >= 0, 1);
        if (err) begin
            chk("err_resp_cycle", rv_cyc, 2);
            chk("err_no_write", we_cnt, 0);
        end else begin
            chk("resp_cycle", rv_cyc, 3);
            chk("we_cycle", we_cyc, 2);
            chk("we_count", we_cnt, 1);
        end
        e = exp_q.pop_front();
        chk("resp_err", resp_err, e[2]);
        if (!e[2]) chk("resp_way", resp_way, e[1:0]);
        chk("req_ready_busy", req_ready, 0);
        chk("index_stable", lru_index, idx);
        if (hold > 0) begin
            way_s = resp_way; err_s = resp_err;
            req_valid = 1'b1; req_index = idx ^ 10'h001; req_way_mask = 4'hf;
            repeat (hold) begin
                @(negedge clk);
                chk("hold_valid", resp_valid, 1);
                chk("hold_way", resp_way, way_s);
                chk("hold_err", resp_err, err_s);
                chk("hold_ready", req_ready, 0);
                chk("hold_index", lru_index, idx);
                chk("hold_no_we", lru_req_we, 0);
            end
            req_valid = 1'b0;
            resp_ready = 1'b1;
        end
        @(negedge clk);
        chk("post_resp_valid", resp_valid, 0);
        chk("post_req_ready", req_ready, 1);
        if (!err) for (int i = 0; i < 4; i++) ref_age[idx][i] = na[i];
        chk("mem_contents", mem[idx], pack_ref(idx));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a [4];
        rst = 1'b1; mem_clr = 1'b1; pl_en = 1'b0; pl_idx = '0; pl_data = '0;
        req_valid = 1'b0; req_index = '0; req_hit = 1'b0; req_way = '0; req_way_mask = '0;
        resp_ready = 1'b1;
        for (int s = 0; s < 1024; s++) for (int w = 0; w < 4; w++) ref_age[s][w] = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_way", resp_way, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_we", lru_req_we, 0);
        chk("rst_index", lru_index, 0);
        chk("rst_write", lru_write, 0);
        rst = 1'b0; mem_clr = 1'b0;

        // All-zero set, full-mask miss -> way 0 becomes MRU, rest age to 1.
        access(10'd5, 1'b0, 2'd0, 4'b1111, 0);
        chk("plan_miss_zero", mem[5], 8'h54);
        chk("plan_miss_way", resp_way, 0);
        access(10'd5, 1'b1, 2'd3, 4'b1111, 0);
        chk("plan_hit3", mem[5], 8'h15);

        // Partitioned miss: only ways 0/1 may change.
        a = '{3, 2, 1, 0};
        preload(10'd9, a);
        access(10'd9, 1'b0, 2'd0, 4'b0011, 0);
        chk("plan_masked_miss", mem[9], 8'h1C);

        access(10'd9, 1'b0, 2'd0, 4'b0000, 0);
        access(10'd9, 1'b1, 2'd2, 4'b0011, 0);
        chk("plan_err_untouched", mem[9], 8'h1C);

        access(10'd5, 1'b1, 2'd0, 4'b1111, 5);
        access(10'd9, 1'b0, 2'd1, 4'b0011, 3);

        // Reset while the write is on the bus: no write, no response.
        @(negedge clk);
        req_valid = 1'b1; req_index = 10'd30; req_hit = 1'b0; req_way_mask = 4'hf;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_we_before", lru_req_we, 1);
        #1 rst = 1'b1;
        #1;
        chk("abort_we_now", lru_req_we, 0);
        chk("abort_resp_valid", resp_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_mem", mem[30], 8'h00);
        repeat (3) begin
            @(negedge clk);
            chk("abort_req_ready", req_ready, 1);
            chk("abort_no_resp", resp_valid, 0);
            chk("abort_no_we", lru_req_we, 0);
        end

        for (int n = 0; n < 150; n++) begin
            logic [3:0] m;
            m = ($urandom_range(0, 9) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
            access(10'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   2'($urandom_range(0, 3)), m, $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
